// File: rtl/key_search_if.sv
// Handshake and status bundle between a search core's sequencer and its controller / RC4 loop FSM.
// The sequencer uses the slave view; the controlling side uses the master view.
interface key_search_if #(
  parameter int unsigned KEY_WIDTH = 24
);
  logic                 start;
  logic                 abort;
  logic                 tm_done;
  logic                 msg_valid;
  logic                 tm_reset;
  logic                 new_key_available;
  logic                 busy;
  logic                 key_found;
  logic                 exhausted;
  logic                 timeout_err;
  logic [KEY_WIDTH-1:0] secret_key;
  logic [KEY_WIDTH-1:0] found_key;
  logic [KEY_WIDTH-1:0] keys_tried;

  modport master (
    output start, abort, tm_done, msg_valid,
    input  tm_reset, new_key_available, busy, key_found, exhausted, timeout_err,
    input  secret_key, found_key, keys_tried
  );

  modport slave (
    input  start, abort, tm_done, msg_valid,
    output tm_reset, new_key_available, busy, key_found, exhausted, timeout_err,
    output secret_key, found_key, keys_tried
  );
endinterface

// File: rtl/key_search_sequencer.sv
// Brute-force key-search scheduler: steps candidate keys through the RC4 loop FSM and
// stops on a valid key, range exhaustion or a watchdog timeout.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no search; loop FSM held in reset
// S_LOAD_KEY  | register current candidate onto secret_key
// S_RESET_TM  | hold loop FSM reset for RESET_CYCLES cycles
// S_KEY_READY | one-cycle new_key_available pulse, watchdog cleared
// S_WAIT_RUN  | loop FSM running; wait for tm_done or watchdog expiry
// S_CHECK     | sample msg_valid, advance to next candidate or finish
// S_FOUND     | terminal: valid key found
// S_EXHAUSTED | terminal: range done without a valid key
// S_TIMEOUT   | terminal: loop FSM never reported done
module key_search_sequencer #(
  parameter int unsigned          KEY_WIDTH       = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START       = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END         = KEY_WIDTH'(24'h3FFFFF),
  parameter int unsigned          STRIDE          = 1,
  parameter int unsigned          RESET_CYCLES    = 2,
  parameter int unsigned          WATCHDOG_CYCLES = 20'hFFFFF
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  key_search_if.slave bus
);

  localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [KEY_WIDTH:0]   STRIDE_X = (KEY_WIDTH + 1)'(STRIDE);
  localparam logic [KEY_WIDTH:0]   END_X    = {1'b0, KEY_END};

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_RESET_TM,
    S_KEY_READY,
    S_WAIT_RUN,
    S_CHECK,
    S_FOUND,
    S_EXHAUSTED,
    S_TIMEOUT
  } state_t;

  state_t               state, state_nxt;
  logic [KEY_WIDTH-1:0] cur_key;
  logic [KEY_WIDTH-1:0] secret_key;
  logic [KEY_WIDTH-1:0] found_key;
  logic [KEY_WIDTH-1:0] keys_tried;
  logic [RC_W-1:0]      rst_cnt;
  logic [WD_W-1:0]      wd_cnt;
  logic [KEY_WIDTH:0]   nxt_key;
  logic                 range_done;

  // One extra bit so a step past the top of the key space reads as exhaustion, not a wrap.
  assign nxt_key    = {1'b0, cur_key} + STRIDE_X;
  assign range_done = nxt_key > END_X;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_TIMEOUT:
          if (bus.start) state_nxt = S_LOAD_KEY;
        S_LOAD_KEY:  state_nxt = S_RESET_TM;
        S_RESET_TM:  if (rst_cnt == RC_LAST) state_nxt = S_KEY_READY;
        S_KEY_READY: state_nxt = S_WAIT_RUN;
        S_WAIT_RUN: begin
          if (bus.tm_done)           state_nxt = S_CHECK;
          else if (wd_cnt == WD_LAST) state_nxt = S_TIMEOUT;
        end
        S_CHECK: begin
          if (bus.msg_valid)  state_nxt = S_FOUND;
          else if (range_done) state_nxt = S_EXHAUSTED;
          else                 state_nxt = S_LOAD_KEY;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_key    <= '0;
      secret_key <= '0;
      found_key  <= '0;
      keys_tried <= '0;
      rst_cnt    <= '0;
      wd_cnt     <= '0;
    end else if (!bus.abort) begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_TIMEOUT: begin
          if (bus.start) begin
            cur_key    <= KEY_START;
            keys_tried <= '0;
          end
        end
        S_LOAD_KEY: begin
          secret_key <= cur_key;
          rst_cnt    <= '0;
        end
        S_RESET_TM:  rst_cnt <= rst_cnt + RC_W'(1);
        S_KEY_READY: wd_cnt  <= '0;
        S_WAIT_RUN:  wd_cnt  <= wd_cnt + WD_W'(1);
        S_CHECK: begin
          keys_tried <= keys_tried + KEY_WIDTH'(1);
          if (bus.msg_valid)   found_key <= secret_key;
          else if (!range_done) cur_key  <= nxt_key[KEY_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // tm_reset drops in terminal states so the loop FSM's FINAL outputs stay readable.
  assign bus.tm_reset          = (state == S_IDLE) || (state == S_RESET_TM);
  assign bus.new_key_available = (state == S_KEY_READY);
  assign bus.busy              = (state == S_LOAD_KEY) || (state == S_RESET_TM) ||
                                 (state == S_KEY_READY) || (state == S_WAIT_RUN) ||
                                 (state == S_CHECK);
  assign bus.key_found         = (state == S_FOUND);
  assign bus.exhausted         = (state == S_EXHAUSTED);
  assign bus.timeout_err       = (state == S_TIMEOUT);
  assign bus.secret_key        = secret_key;
  assign bus.found_key         = found_key;
  assign bus.keys_tried        = keys_tried;

endmodule

// File: tb/tb_key_search_sequencer.sv
// Randomized bench for key_search_sequencer: three cores with different ranges/strides,
// a behavioural loop-FSM responder, and a key-range reference model.
module tb_key_search_sequencer;

  localparam logic [2:0][23:0] P_START  = {24'hFFFFFF, 24'd1, 24'd0};
  localparam logic [2:0][23:0] P_END    = {24'hFFFFFF, 24'd6, 24'd7};
  localparam logic [2:0][7:0]  P_STRIDE = {8'd1, 8'd2, 8'd1};
  localparam logic [2:0][7:0]  P_RC     = {8'd1, 8'd3, 8'd2};
  localparam logic [2:0][15:0] P_WD     = {16'd64, 16'd64, 16'd16};

  logic CLOCK_50;
  logic reset_n;

  logic        start_s[3], abort_s[3], tm_done_s[3], msg_valid_s[3];
  logic        tm_reset_s[3], nka_s[3], busy_s[3], found_s[3], exh_s[3], to_s[3];
  logic [23:0] secret_s[3], found_key_s[3], tried_s[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    key_search_if #(.KEY_WIDTH(24)) bus ();
    assign bus.start       = start_s[g];
    assign bus.abort       = abort_s[g];
    assign bus.tm_done     = tm_done_s[g];
    assign bus.msg_valid   = msg_valid_s[g];
    assign tm_reset_s[g]   = bus.tm_reset;
    assign nka_s[g]        = bus.new_key_available;
    assign busy_s[g]       = bus.busy;
    assign found_s[g]      = bus.key_found;
    assign exh_s[g]        = bus.exhausted;
    assign to_s[g]         = bus.timeout_err;
    assign secret_s[g]     = bus.secret_key;
    assign found_key_s[g]  = bus.found_key;
    assign tried_s[g]      = bus.keys_tried;

    key_search_sequencer #(
      .KEY_WIDTH       (24),
      .KEY_START       (P_START[g]),
      .KEY_END         (P_END[g]),
      .STRIDE          (32'(P_STRIDE[g])),
      .RESET_CYCLES    (32'(P_RC[g])),
      .WATCHDOG_CYCLES (32'(P_WD[g]))
    ) u_dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .bus      (bus)
    );
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          t_nka, t_end;
  logic [23:0] q_keys[$];
  int          q_runs[$];

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
    cyc++;
  endtask

  // Plays the loop FSM: answers each new_key_available after a random run time with
  // tm_done held until the next tm_reset; pokes start while busy to prove it is ignored.
  task automatic run_search(input int d, input bit tgt_en, input logic [23:0] tgt,
                            input bit respond, input int stop_nka, input int lat_max);
    int budget, lat, n, hi_run;
    bit fin;
    q_keys.delete();
    q_runs.delete();
    hi_run = 0; n = 0; fin = 0; budget = 3000;
    start_s[d] = 1'b1;
    step();
    start_s[d] = 1'b0;
    while (!fin && budget > 0) begin
      if (tm_reset_s[d]) begin
        hi_run++;
        tm_done_s[d]   = 1'b0;
        msg_valid_s[d] = 1'($urandom);
      end else if (nka_s[d]) begin
        q_runs.push_back(hi_run);
        hi_run = 0;
        q_keys.push_back(secret_s[d]);
        n++;
        t_nka = cyc;
        if (n == stop_nka) begin
          start_s[d] = 1'b0;
          return;
        end
        if (respond) begin
          lat = $urandom_range(0, lat_max);
          repeat (lat) step();
          budget -= lat;
          msg_valid_s[d] = tgt_en && (secret_s[d] == tgt);
          tm_done_s[d]   = 1'b1;
        end
      end else begin
        hi_run = 0;
      end
      if (found_s[d] || exh_s[d] || to_s[d]) begin
        fin        = 1'b1;
        t_end      = cyc;
        start_s[d] = 1'b0;
      end else begin
        start_s[d] = ($urandom_range(0, 3) == 0);
        step();
        budget--;
      end
    end
    start_s[d] = 1'b0;
    check_val("run_terminated", 32'(fin), 32'd1);
  endtask

  // Reference: candidates are START, START+STRIDE, ... up to END, stopping at the valid key.
  task automatic verify(input int d, input bit tgt_en, input logic [23:0] tgt);
    logic [23:0] exp_keys[$];
    longint k;
    bit hit;
    int cnt;
    k = longint'(P_START[d]);
    while (k <= longint'(P_END[d])) begin
      exp_keys.push_back(k[23:0]);
      if (tgt_en && k == longint'(tgt)) break;
      k += longint'(P_STRIDE[d]);
    end
    hit = tgt_en && (exp_keys[$] == tgt);
    check_val("n_keys", 32'(q_keys.size()), 32'(exp_keys.size()));
    for (int i = 0; i < q_keys.size() && i < exp_keys.size(); i++)
      check_val("key_seq", 32'(q_keys[i]), 32'(exp_keys[i]));
    foreach (q_runs[i]) check_val("reset_len", 32'(q_runs[i]), 32'(P_RC[d]));
    check_val("keys_tried", 32'(tried_s[d]), 32'(exp_keys.size()));
    check_val("key_found", 32'(found_s[d]), 32'(hit));
    check_val("exhausted", 32'(exh_s[d]), 32'(!hit));
    check_val("timeout_err", 32'(to_s[d]), 32'd0);
    check_val("busy_end", 32'(busy_s[d]), 32'd0);
    check_val("tm_reset_end", 32'(tm_reset_s[d]), 32'd0);
    check_val("last_secret", 32'(secret_s[d]), 32'(exp_keys[$]));
    if (hit) check_val("found_key", 32'(found_key_s[d]), 32'(tgt));
    cnt = 0;
    repeat (6) begin
      step();
      if (nka_s[d]) cnt++;
    end
    check_val("extra_nka", 32'(cnt), 32'd0);
  endtask

  initial begin
    logic [23:0] tgt;
    bit          en;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 0; abort_s[d] = 0; tm_done_s[d] = 0; msg_valid_s[d] = 0;
    end
    reset_n = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      check_val("rst_tm_reset", 32'(tm_reset_s[d]), 32'd1);
      check_val("rst_busy", 32'(busy_s[d]), 32'd0);
      check_val("rst_nka", 32'(nka_s[d]), 32'd0);
      check_val("rst_flags", 32'({found_s[d], exh_s[d], to_s[d]}), 32'd0);
      check_val("rst_secret", 32'(secret_s[d]), 32'd0);
      check_val("rst_found_key", 32'(found_key_s[d]), 32'd0);
      check_val("rst_keys_tried", 32'(tried_s[d]), 32'd0);
    end
    reset_n = 1'b1;
    step();

    // Core 0: range 0..7, valid key 5, then random targets (8, 9 are outside the range).
    run_search(0, 1'b1, 24'd5, 1'b1, 0, 8);
    verify(0, 1'b1, 24'd5);
    for (int it = 0; it < 6; it++) begin
      tgt = 24'($urandom_range(0, 9));
      en  = 1'($urandom);
      run_search(0, en, tgt, 1'b1, 0, 8);
      verify(0, en, tgt);
    end

    // Watchdog: tm_done never arrives.
    run_search(0, 1'b0, 24'd0, 1'b0, 0, 0);
    check_val("timeout_err", 32'(to_s[0]), 32'd1);
    check_val("timeout_cycles", 32'(t_end - t_nka), 32'(P_WD[0]) + 32'd1);
    check_val("timeout_tm_reset", 32'(tm_reset_s[0]), 32'd0);
    check_val("timeout_busy", 32'(busy_s[0]), 32'd0);
    check_val("timeout_tried", 32'(tried_s[0]), 32'd0);

    // Abort in WAIT_RUN on the second key, with start asserted alongside.
    run_search(0, 1'b0, 24'd0, 1'b1, 2, 4);
    step();
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    step();
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    check_val("abort_tm_reset", 32'(tm_reset_s[0]), 32'd1);
    check_val("abort_busy", 32'(busy_s[0]), 32'd0);
    check_val("abort_flags", 32'({found_s[0], exh_s[0], to_s[0]}), 32'd0);
    check_val("abort_tried", 32'(tried_s[0]), 32'd1);
    repeat (3) step();
    check_val("abort_idle_hold", 32'(busy_s[0]), 32'd0);
    run_search(0, 1'b1, 24'd3, 1'b1, 0, 6);
    verify(0, 1'b1, 24'd3);

    // Core 1: stride 2 from 1 to 6.
    for (int it = 0; it < 4; it++) begin
      tgt = 24'(2 * $urandom_range(0, 3) + 1);
      en  = (it != 0);
      run_search(1, en, tgt, 1'b1, 0, 10);
      verify(1, en, tgt);
    end

    // Core 2: single key at the top of the key space.
    run_search(2, 1'b0, 24'd0, 1'b1, 0, 5);
    verify(2, 1'b0, 24'd0);
    run_search(2, 1'b1, 24'hFFFFFF, 1'b1, 0, 5);
    verify(2, 1'b1, 24'hFFFFFF);

    // Async reset in the middle of RESET_TM on core 1.
    start_s[1] = 1'b1;
    step();
    start_s[1] = 1'b0;
    step();
    check_val("pre_rst_tm_reset", 32'(tm_reset_s[1]), 32'd1);
    check_val("pre_rst_secret", 32'(secret_s[1]), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_val("arst_secret", 32'(secret_s[1]), 32'd0);
    check_val("arst_busy", 32'(busy_s[1]), 32'd0);
    check_val("arst_tm_reset", 32'(tm_reset_s[1]), 32'd1);
    check_val("arst_tried", 32'(tried_s[1]), 32'd0);
    check_val("arst_found_key", 32'(found_key_s[0]), 32'd0);
    check_val("arst_flags", 32'({found_s[2], exh_s[2], to_s[2]}), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    run_search(1, 1'b1, 24'd3, 1'b1, 0, 6);
    verify(1, 1'b1, 24'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
